// File: rtl/moore_phase_seq.sv
// Moore phase sequencer: steps through N_PHASES phases, dwelling DWELL enabled cycles in each,
// with hold, bypass, direction control, one-hot decode and a one-cycle wrap flag.
//   action      | meaning
//   ACT_IDLE    | no enable, phase and dwell count stay put
//   ACT_COUNT   | enabled, dwell count increments
//   ACT_ADVANCE | dwell expired or bypass, move to next phase
//   ACT_FREEZE  | hold, all state frozen
module moore_phase_seq #(
    parameter int N_PHASES = 4,
    parameter int PW       = 2,
    parameter int DWELL    = 4,
    parameter int DW       = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                bypass,
    input  logic                hold,
    input  logic                dir,
    output logic [PW-1:0]       out,
    output logic [N_PHASES-1:0] onehot,
    output logic [DW-1:0]       dwell_cnt,
    output logic                wrap
);

    localparam int                PW1      = PW + 1;
    localparam logic [PW:0]       NP       = PW1'(N_PHASES);
    localparam logic [PW-1:0]     LAST_PH  = PW'(N_PHASES - 1);
    localparam logic [DW-1:0]     CNT_LAST = DW'(DWELL - 1);
    localparam logic [N_PHASES-1:0] ONE    = N_PHASES'(1);

    typedef enum logic [1:0] {
        ACT_IDLE,
        ACT_COUNT,
        ACT_ADVANCE,
        ACT_FREEZE
    } act_e;

    act_e                act;
    logic [PW-1:0]       phase_q, phase_d, phase_nxt;
    logic [DW-1:0]       cnt_q, cnt_d;
    logic                wrap_q, wrap_d;
    logic                crosses;
    logic [N_PHASES-1:0] onehot_q, onehot_d;

    always_comb begin
        act = ACT_IDLE;
        if (hold) begin
            act = ACT_FREEZE;
        end else if (bypass) begin
            act = ACT_ADVANCE;
        end else if (en) begin
            act = (cnt_q == CNT_LAST) ? ACT_ADVANCE : ACT_COUNT;
        end
    end

    // Out-of-range codes recover to phase 0 regardless of direction.
    always_comb begin
        phase_nxt = '0;
        crosses   = 1'b0;
        if ({1'b0, phase_q} >= NP) begin
            phase_nxt = '0;
        end else if (dir) begin
            phase_nxt = (phase_q == '0) ? LAST_PH : phase_q - PW'(1);
            crosses   = (phase_q == '0);
        end else begin
            phase_nxt = (phase_q == LAST_PH) ? '0 : phase_q + PW'(1);
            crosses   = (phase_q == LAST_PH);
        end
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        case (act)
            ACT_ADVANCE: begin
                phase_d = phase_nxt;
                cnt_d   = '0;
                wrap_d  = crosses;
            end
            ACT_COUNT:  cnt_d = cnt_q + DW'(1);
            default:    ;
        endcase
        onehot_d = ONE << phase_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= '0;
            cnt_q    <= '0;
            wrap_q   <= 1'b0;
            onehot_q <= ONE;
        end else begin
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            wrap_q   <= wrap_d;
            onehot_q <= onehot_d;
        end
    end

    assign out       = phase_q;
    assign onehot    = onehot_q;
    assign dwell_cnt = cnt_q;
    assign wrap      = wrap_q;

endmodule

// File: doc/moore_phase_seq.md
Name: moore_phase_seq

Overview:
- Parametrised Moore phase sequencer; successor to the fixed 2-bit Moore FSM with bypass.
- Cycles through N_PHASES phases, holding each for DWELL enabled cycles.
- Adds hold, direction control, one-hot decode and a wrap pulse.
- Drives phase-selection for downstream control logic (e.g. light/step sequencing); all outputs depend only on state.

Parameters:
- N_PHASES, 4, number of phases (>=2)
- PW, 2, width of phase index; 2**PW >= N_PHASES
- DWELL, 4, enabled cycles spent in each phase (>=1)
- DW, 3, dwell counter width; 2**DW >= DWELL

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- en  in  1  advance dwell counter when high
- bypass  in  1  skip remainder of current phase
- hold  in  1  freeze all state
- dir  in  1  0 = forward (P+1), 1 = reverse (P-1)
- out  out  PW  current phase index
- onehot  out  N_PHASES  onehot[out] = 1, all other bits 0
- dwell_cnt  out  DW  current dwell count C
- wrap  out  1  one-cycle flag: phase wrapped on the previous edge

Behaviour:
- State: phase register P, dwell counter C, wrap register Wq.
  - out = P; dwell_cnt = C; wrap = Wq; onehot is decoded from P only (Moore).
- Reset (rst=1 at an edge): P=0, C=0, Wq=0. Resulting outputs: out=0, onehot=...0001, dwell_cnt=0, wrap=0. Reset overrides every other input, including mid-phase.
- Next-phase function:
  - forward: P==N_PHASES-1 ? 0 : P+1
  - reverse: P==0 ? N_PHASES-1 : P-1
  - dir is sampled on the edge where the advance occurs.
- Per-edge priority: rst > hold > bypass > en > idle.
  - hold=1: P and C unchanged; Wq <= 0.
  - bypass=1 (hold=0): P <= next; C <= 0. Applies regardless of en or C.
  - en=1 and C==DWELL-1: P <= next; C <= 0.
  - en=1 and C<DWELL-1: C <= C+1; P unchanged.
  - en=0 and no bypass: P and C unchanged.
- Wq <= 1 exactly on edges where P advances across the boundary: N_PHASES-1 -> 0 forward, or 0 -> N_PHASES-1 reverse. Otherwise Wq <= 0. wrap is therefore high for one cycle only, even under back-to-back bypass.
- Latency: with en held high from reset release, out changes after exactly DWELL edges. A full forward cycle takes N_PHASES*DWELL edges.
- DWELL=1: C stays 0; the phase advances on every enabled edge.
- Phase codes >= N_PHASES are unreachable. If ever reached, next = 0 in both directions.
- dir changing mid-dwell does not reset C.
- No combinational path from any input to any output.

Test Plan:
- N=4, DWELL=4, rst high 2 cycles then low, en=1, dir=0 -> out sequence 0,1,2,3,0; each value held exactly 4 cycles; dwell_cnt counts 0,1,2,3; wrap=1 for the single cycle after 3->0.
- Same config, bypass pulsed 1 cycle while out=1 and dwell_cnt=1 -> next cycle out=2, dwell_cnt=0. bypass held 3 cycles from out=2 -> out 3,0,1; wrap high only in the cycle with out=0.
- hold=1 for 5 cycles at out=2, dwell_cnt=2, with en=1 and bypass=1 -> out=2 and dwell_cnt=2 unchanged; on hold release, bypass takes effect -> out=3.
- dir=1, en=1 from reset -> out 0 held 4 cycles, then 3,2,1,0; wrap high in the cycle after 0->3.
- rst asserted mid-phase (out=3, dwell_cnt=2) -> next edge out=0, dwell_cnt=0, onehot=4'b0001, wrap=0.
- N_PHASES=5, PW=3, DWELL=1, en=1 -> out 0,1,2,3,4,0 on consecutive cycles; onehot stays one-hot; en=0 freezes the current value.
